// File: rtl/wb_regbank_param.sv
// Parametrised Wishbone pipelined register bank: N_RW read/write control
// registers followed by N_RO read-only status registers, byte-lane write
// masking and a one-cycle write strobe per RW register.
// Optional feature macro: WB_REGBANK_ERR_EN -- when defined, unmapped accesses
// and writes to read-only indices terminate with wb_err_o instead of wb_ack_o.
module wb_regbank_param #(
   parameter int unsigned       DATA_W  = 32,
   parameter int unsigned       N_RW    = 4,
   parameter int unsigned       N_RO    = 2,
   parameter int unsigned       ADDR_W  = 7,
   parameter logic [DATA_W-1:0] RST_VAL = '0
) (
   input  logic                                    clk_i,
   input  logic                                    rst_i,
   input  logic                                    wb_cyc_i,
   input  logic                                    wb_stb_i,
   input  logic [ADDR_W-1:0]                       wb_adr_i,
   input  logic [DATA_W/8-1:0]                     wb_sel_i,
   input  logic                                    wb_we_i,
   input  logic [DATA_W-1:0]                       wb_dat_i,
   output logic                                    wb_ack_o,
   output logic                                    wb_err_o,
   output logic                                    wb_rty_o,
   output logic                                    wb_stall_o,
   output logic [DATA_W-1:0]                       wb_dat_o,
   output logic [N_RW*DATA_W-1:0]                  rw_regs_o,
   output logic [N_RW-1:0]                         rw_wstb_o,
   input  logic [((N_RO == 0) ? 1 : N_RO)*DATA_W-1:0] ro_regs_i
);

   localparam int unsigned SEL_W = DATA_W / 8;

`ifdef WB_REGBANK_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic [DATA_W-1:0] rw_q [N_RW];
   logic [DATA_W-1:0] rw_d [N_RW];
   logic              rip_q, rip_d;
   logic              wip_q, wip_d;
   logic              ack_q, ack_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] dat_q, dat_d;
   logic [N_RW-1:0]   wstb_q, wstb_d;
   logic              d0_vld_q, d0_vld_d;
   logic [ADDR_W-1:0] d0_adr_q, d0_adr_d;
   logic [DATA_W-1:0] d0_dat_q, d0_dat_d;
   logic [SEL_W-1:0]  d0_sel_q, d0_sel_d;

   logic [31:0]       adr_u;
   logic [31:0]       d0_adr_u;
   logic              mapped_c;
   logic              d0_rw_c;
   logic              busy_c;
   logic              accept_c;
   logic [DATA_W-1:0] rd_data_c;

   // Address decode for the live request and for the write stage
   always_comb begin
      adr_u     = 32'(wb_adr_i);
      d0_adr_u  = 32'(d0_adr_q);
      mapped_c  = (adr_u < (N_RW + N_RO));
      d0_rw_c   = (d0_adr_u < N_RW);
      rd_data_c = '0;
      for (int unsigned k = 0; k < N_RW; k++) begin
         if (adr_u == k) rd_data_c = rw_q[k];
      end
      for (int unsigned k = 0; k < N_RO; k++) begin
         if (adr_u == (N_RW + k)) rd_data_c = ro_regs_i[k*DATA_W +: DATA_W];
      end
   end

   // Accept/terminate control, read response and byte-masked register update
   always_comb begin
      busy_c   = (rip_q | wip_q) & ~(ack_q | err_q);
      accept_c = wb_cyc_i & wb_stb_i & ~busy_c;

      rip_d    = rip_q & ~(ack_q | err_q);
      wip_d    = wip_q & ~(ack_q | err_q);
      ack_d    = 1'b0;
      err_d    = 1'b0;
      dat_d    = '0;
      wstb_d   = '0;
      rw_d     = rw_q;
      d0_vld_d = 1'b0;
      d0_adr_d = d0_adr_q;
      d0_dat_d = d0_dat_q;
      d0_sel_d = d0_sel_q;

      if (accept_c) begin
         if (wb_we_i) begin
            wip_d    = 1'b1;
            d0_vld_d = 1'b1;
            d0_adr_d = wb_adr_i;
            d0_dat_d = wb_dat_i;
            d0_sel_d = wb_sel_i;
         end else begin
            rip_d = 1'b1;
            if (mapped_c) begin
               ack_d = 1'b1;
               dat_d = rd_data_c;
            end else if (ERR_EN) begin
               err_d = 1'b1;
            end else begin
               ack_d = 1'b1;
            end
         end
      end

      // Write stage: a write is never accepted while this stage is busy
      if (d0_vld_q) begin
         if (d0_rw_c) begin
            ack_d = 1'b1;
            for (int unsigned k = 0; k < N_RW; k++) begin
               if (d0_adr_u == k) begin
                  wstb_d[k] = |d0_sel_q;
                  for (int unsigned b = 0; b < SEL_W; b++) begin
                     if (d0_sel_q[b]) rw_d[k][b*8 +: 8] = d0_dat_q[b*8 +: 8];
                  end
               end
            end
         end else if (ERR_EN) begin
            err_d = 1'b1;
         end else begin
            ack_d = 1'b1;
         end
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned k = 0; k < N_RW; k++) rw_q[k] <= RST_VAL;
         rip_q    <= 1'b0;
         wip_q    <= 1'b0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         dat_q    <= '0;
         wstb_q   <= '0;
         d0_vld_q <= 1'b0;
         d0_adr_q <= '0;
         d0_dat_q <= '0;
         d0_sel_q <= '0;
      end else begin
         rw_q     <= rw_d;
         rip_q    <= rip_d;
         wip_q    <= wip_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         dat_q    <= dat_d;
         wstb_q   <= wstb_d;
         d0_vld_q <= d0_vld_d;
         d0_adr_q <= d0_adr_d;
         d0_dat_q <= d0_dat_d;
         d0_sel_q <= d0_sel_d;
      end
   end

   // Flatten register contents onto the output bus
   for (genvar g = 0; g < int'(N_RW); g++) begin : g_pack
      assign rw_regs_o[g*DATA_W +: DATA_W] = rw_q[g];
   end

   assign wb_ack_o   = ack_q;
   assign wb_err_o   = err_q;
   assign wb_rty_o   = 1'b0;
   assign wb_stall_o = wb_cyc_i & wb_stb_i & ~(ack_q | err_q);
   assign wb_dat_o   = dat_q;
   assign rw_wstb_o  = wstb_q;

endmodule

// File: tb/tb_wb_regbank_param.sv
// Directed bench for wb_regbank_param (default parameters); expected
// terminations are queued at drive time and popped when the bank responds.
module tb_wb_regbank_param;

`ifdef WB_REGBANK_ERR_EN
   localparam bit ERR = 1'b1;
`else
   localparam bit ERR = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_i = 1'b1;
   logic         wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
   logic [6:0]   wb_adr_i = '0;
   logic [3:0]   wb_sel_i = '0;
   logic [31:0]  wb_dat_i = '0;
   logic         wb_ack_o, wb_err_o, wb_rty_o, wb_stall_o;
   logic [31:0]  wb_dat_o;
   logic [127:0] rw_regs_o;
   logic [3:0]   rw_wstb_o;
   logic [63:0]  ro_regs_i = '0;

   typedef struct {
      bit          err;
      bit          rd;
      int          lat;
      logic [31:0] dat;
      logic [3:0]  wstb;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model [4];
   int          n_cmp = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   wb_regbank_param dut (
      .clk_i(clk), .rst_i(rst_i),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_adr_i(wb_adr_i),
      .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_dat_i(wb_dat_i),
      .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
      .wb_stall_o(wb_stall_o), .wb_dat_o(wb_dat_o),
      .rw_regs_o(rw_regs_o), .rw_wstb_o(rw_wstb_o), .ro_regs_i(ro_regs_i)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_regs(input string tag);
      for (int k = 0; k < 4; k++)
         chk($sformatf("%s_reg%0d", tag, k), 64'(rw_regs_o[k*32 +: 32]), 64'(model[k]));
   endtask

   task automatic model_write(input logic [6:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      if (adr < 7'd4)
         for (int b = 0; b < 4; b++)
            if (sel[b]) model[adr][b*8 +: 8] = dat[b*8 +: 8];
   endtask

   // One single-beat transfer; called and returning on a falling edge
   task automatic xfer(input string tag, input bit we, input logic [6:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel,
                       input logic [31:0] exp_dat, input bit exp_err, input logic [3:0] exp_wstb);
      exp_t e;
      bit   got;
      int   lat;
      e.err = exp_err; e.rd = !we; e.lat = we ? 2 : 1; e.dat = exp_dat; e.wstb = exp_wstb;
      sb.push_back(e);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
      wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
      #1;
      chk({tag, "_stall"}, 64'(wb_stall_o), 64'd1);
      @(negedge clk);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      got = 1'b0; lat = 0;
      for (int i = 1; i <= 4 && !got; i++) begin
         if (wb_ack_o || wb_err_o) begin
            got = 1'b1; lat = i;
         end else begin
            @(negedge clk);
         end
      end
      if (!got) begin
         chk({tag, "_terminated"}, 64'd0, 64'd1);
         void'(sb.pop_front());
      end else begin
         e = sb.pop_front();
         chk({tag, "_latency"}, 64'(lat), 64'(e.lat));
         chk({tag, "_ack"}, 64'(wb_ack_o), 64'(!e.err));
         chk({tag, "_err"}, 64'(wb_err_o), 64'(e.err));
         if (e.rd) chk({tag, "_rdata"}, 64'(wb_dat_o), 64'(e.dat));
         else      chk({tag, "_wstb"}, 64'(rw_wstb_o), 64'(e.wstb));
         @(negedge clk);
         chk({tag, "_single_term"}, 64'(wb_ack_o | wb_err_o), 64'd0);
      end
      chk({tag, "_wstb_idle"}, 64'(rw_wstb_o), 64'd0);
   endtask

   initial begin
      for (int k = 0; k < 4; k++) model[k] = 32'h0;

      // Reset held for two cycles
      @(negedge clk); @(negedge clk);
      chk_regs("reset");
      chk("reset_ack", 64'(wb_ack_o), 64'd0);
      chk("reset_err", 64'(wb_err_o), 64'd0);
      chk("reset_stall", 64'(wb_stall_o), 64'd0);
      chk("reset_wstb", 64'(rw_wstb_o), 64'd0);
      chk("reset_dat", 64'(wb_dat_o), 64'd0);
      chk("rty", 64'(wb_rty_o), 64'd0);
      rst_i = 1'b0;
      @(negedge clk);

      // Full and partial byte-lane writes to reg 1
      xfer("wr1_full", 1'b1, 7'd1, 32'hA5A5_5A5A, 4'hF, 32'h0, 1'b0, 4'b0010);
      model_write(7'd1, 32'hA5A5_5A5A, 4'hF);
      chk("wr1_full_val", 64'(rw_regs_o[63:32]), 64'h0000_0000_A5A5_5A5A);
      xfer("wr1_part", 1'b1, 7'd1, 32'hFFFF_FFFF, 4'b0101, 32'h0, 1'b0, 4'b0010);
      model_write(7'd1, 32'hFFFF_FFFF, 4'b0101);
      chk("wr1_part_val", 64'(rw_regs_o[63:32]), 64'h0000_0000_A5FF_5AFF);
      xfer("rd1", 1'b0, 7'd1, 32'h0, 4'h0, 32'hA5FF_5AFF, 1'b0, 4'h0);

      // Status registers
      ro_regs_i = {32'hCAFE_F00D, 32'h1234_5678};
      xfer("rd_ro4", 1'b0, 7'd4, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 4'h0);
      xfer("rd_ro5", 1'b0, 7'd5, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 4'h0);
      xfer("wr_ro4", 1'b1, 7'd4, 32'hDEAD_BEEF, 4'hF, 32'h0, ERR, 4'h0);
      chk_regs("wr_ro4");
      xfer("rd_ro4_again", 1'b0, 7'd4, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 4'h0);

      // Unmapped accesses
      xfer("rd_unmapped", 1'b0, 7'h7F, 32'h0, 4'h0, 32'h0, ERR, 4'h0);
      xfer("wr_unmapped", 1'b1, 7'h10, 32'h5555_AAAA, 4'hF, 32'h0, ERR, 4'h0);
      chk_regs("wr_unmapped");

      // Zero byte-enable write and a full write to the last RW register
      xfer("wr0_sel0", 1'b1, 7'd0, 32'h7777_7777, 4'h0, 32'h0, 1'b0, 4'h0);
      chk_regs("wr0_sel0");
      xfer("wr3", 1'b1, 7'd3, 32'h1122_3344, 4'hF, 32'h0, 1'b0, 4'b1000);
      model_write(7'd3, 32'h1122_3344, 4'hF);
      chk_regs("wr3");
      xfer("rd3", 1'b0, 7'd3, 32'h0, 4'h0, model[3], 1'b0, 4'h0);

      // Strobe held through a write: stall until the acknowledge cycle
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
      wb_adr_i = 7'd0; wb_dat_i = 32'h0BAD_F00D; wb_sel_i = 4'b1100;
      #1 chk("hold_stall_t", 64'(wb_stall_o), 64'd1);
      @(negedge clk);
      chk("hold_stall_t1", 64'(wb_stall_o), 64'd1);
      chk("hold_ack_t1", 64'(wb_ack_o), 64'd0);
      @(negedge clk);
      chk("hold_ack_t2", 64'(wb_ack_o), 64'd1);
      chk("hold_stall_t2", 64'(wb_stall_o), 64'd0);
      chk("hold_wstb_t2", 64'(rw_wstb_o), 64'b0001);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      model_write(7'd0, 32'h0BAD_F00D, 4'b1100);
      @(negedge clk);
      chk("hold_single_ack", 64'(wb_ack_o), 64'd0);
      chk("hold_val", 64'(rw_regs_o[31:0]), 64'h0000_0000_0BAD_0000);

      // Back-to-back reads: second is accepted in the first one's ack cycle
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 7'd1;
      @(negedge clk);
      chk("b2b_ack_a", 64'(wb_ack_o), 64'd1);
      chk("b2b_dat_a", 64'(wb_dat_o), 64'(model[1]));
      wb_adr_i = 7'd3;
      @(negedge clk);
      chk("b2b_ack_b", 64'(wb_ack_o), 64'd1);
      chk("b2b_dat_b", 64'(wb_dat_o), 64'(model[3]));
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      @(negedge clk);
      chk("b2b_single_ack", 64'(wb_ack_o), 64'd0);
      chk("b2b_dat_clear", 64'(wb_dat_o), 64'd0);

      // Reset in the cycle after a write is accepted drops it silently
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
      wb_adr_i = 7'd2; wb_dat_i = 32'hDEAD_BEEF; wb_sel_i = 4'hF;
      @(negedge clk);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      for (int k = 0; k < 4; k++) model[k] = 32'h0;
      chk("rstmid_ack", 64'(wb_ack_o), 64'd0);
      chk("rstmid_err", 64'(wb_err_o), 64'd0);
      chk("rstmid_wstb", 64'(rw_wstb_o), 64'd0);
      chk_regs("rstmid");
      @(negedge clk);
      chk("rstmid_ack_late", 64'(wb_ack_o), 64'd0);
      chk("rstmid_wstb_late", 64'(rw_wstb_o), 64'd0);
      chk_regs("rstmid_late");
      xfer("rd2_after_rst", 1'b0, 7'd2, 32'h0, 4'h0, 32'h0, 1'b0, 4'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
